// File: rtl/sigm_share_sched_if.sv
// Handshake bundle between the gate requesters, the shared sigmoid scheduler
// and the downstream cell-state consumer.
interface sigm_share_sched_if #(
  parameter int WIDTH = 24,
  parameter int NREQ  = 3,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/sigm_share_sched.sv
// Round-robin sharing of one 3-segment PWL sigmoid among NREQ LSTM gate requesters,
// with a two-register pipeline (operand+tag, result+tag) and valid/ready on both sides.
module sigm_share_sched #(
  parameter int WIDTH = 24,
  parameter int NREQ  = 3,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    cfg_mask,
  sigm_share_sched_if.slave  bus,
  output logic               busy,
  output logic [CNTW-1:0]    done_cnt
);

  if (WIDTH != 24) begin : g_bad_width
    $error("sigm_share_sched: sigmf segment constants assume WIDTH=24");
  end
  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("sigm_share_sched: NREQ must be 2..4");
  end

  // Saturating 3-segment approximation; x is range-compared as an unsigned word.
  function automatic logic signed [WIDTH-1:0] sigmf(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0]        xu;
    logic signed [WIDTH-1:0] sh3;
    logic signed [WIDTH-1:0] sh2;
    xu  = x;
    sh3 = x >>> 3;
    sh2 = x >>> 2;
    if (xu > 24'h333333 && xu < 24'hCCCCCC)
      sigmf = x[WIDTH-1] ? 24'sh000000 : 24'sh100000;
    else if (xu > 24'h0CCCCC && xu < 24'hF33333)
      sigmf = sh3 + (x[WIDTH-1] ? 24'sh066666 : 24'sh099999);
    else
      sigmf = sh2 + 24'sh080000;
  endfunction

  logic [NREQ-1:0]         elig;
  logic                    gnt_vld;
  logic [IDW-1:0]          gnt_id;
  logic [IDW:0]            idx_w;

  logic                    s1_adv;
  logic                    s0_adv;
  logic                    s0_free;
  logic                    xfer;

  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;

  logic                    vld_p0_q, vld_p0_d;
  logic signed [WIDTH-1:0] data_p0_q;
  logic [IDW-1:0]          id_p0_q;

  logic                    vld_p1_q, vld_p1_d;
  logic signed [WIDTH-1:0] data_p1_q, data_p1_d;
  logic [IDW-1:0]          id_p1_q, id_p1_d;

  assign elig = bus.req_valid & cfg_mask;

  // First eligible requester scanning upward from the round-robin pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx_w   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx_w = {1'b0, ptr_q} + (IDW+1)'(i);
      if (idx_w >= (IDW+1)'(NREQ))
        idx_w = idx_w - (IDW+1)'(NREQ);
      if (!gnt_vld && elig[idx_w[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx_w[IDW-1:0];
      end
    end
  end

  assign s1_adv  = ~vld_p1_q | bus.out_ready;
  assign s0_adv  = vld_p0_q & s1_adv;
  assign s0_free = ~vld_p0_q | s0_adv;
  assign xfer    = ~rst & s0_free & gnt_vld;

  assign bus.req_ready = xfer ? (NREQ'(1) << gnt_id) : '0;

  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    vld_p0_d  = vld_p0_q;
    vld_p1_d  = vld_p1_q;
    data_p1_d = data_p1_q;
    id_p1_d   = id_p1_q;

    if (xfer)
      ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);

    if (xfer)
      vld_p0_d = 1'b1;
    else if (s0_adv)
      vld_p0_d = 1'b0;

    if (s0_adv) begin
      vld_p1_d  = 1'b1;
      data_p1_d = sigmf(data_p0_q);
      id_p1_d   = id_p0_q;
    end else if (bus.out_ready) begin
      vld_p1_d  = 1'b0;
    end

    if (vld_p1_q && bus.out_ready)
      cnt_d = cnt_q + CNTW'(1);
  end

  // ---- stage 0: operand and tag capture ----
  always_ff @(posedge clk) begin
    if (xfer) begin
      data_p0_q <= bus.req_data[gnt_id*WIDTH +: WIDTH];
      id_p0_q   <= gnt_id;
    end
  end

  // ---- stage 1: result and tag, plus scheduler control ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      id_p1_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      data_p1_q <= data_p1_d;
      id_p1_q   <= id_p1_d;
    end
  end

  assign bus.out_valid = vld_p1_q;
  assign bus.out_data  = data_p1_q;
  assign bus.out_id    = id_p1_q;
  assign busy          = vld_p0_q | vld_p1_q;
  assign done_cnt      = cnt_q;

endmodule

// File: tb/tb_sigm_share_sched.sv
// Scoreboard bench for the shared sigmoid scheduler: directed operands with
// hand-computed results, round-robin order, backpressure, reset and counter wrap.
module tb_sigm_share_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cfg_mask;
  logic       busy;
  logic [3:0] done_cnt;

  sigm_share_sched_if #(.WIDTH(24), .NREQ(3), .IDW(2)) bus ();

  sigm_share_sched #(.WIDTH(24), .NREQ(3), .IDW(2), .CNTW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_mask (cfg_mask),
    .bus      (bus.slave),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] d;
    logic [1:0]  id;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   seq[32];

  localparam int NV = 11;
  localparam logic [1:0]  V_K [NV] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
  localparam logic [23:0] V_X [NV] = '{24'h000000, 24'h040000, 24'h100000, 24'h040000, 24'h400000,
                                       24'hC00000, 24'h333333, 24'hCCCCCC, 24'h0CCCCC, 24'hF33333,
                                       24'hFFFFFF};
  localparam logic [23:0] V_Y [NV] = '{24'h080000, 24'h090000, 24'h0B9999, 24'h090000, 24'h100000,
                                       24'h000000, 24'h0FFFFF, 24'hFFFFFF, 24'h0B3333, 24'h04CCCC,
                                       24'h07FFFF};
  localparam logic [23:0] R_X [3] = '{24'h000000, 24'h040000, 24'h100000};
  localparam logic [23:0] R_Y [3] = '{24'h080000, 24'h090000, 24'h0B9999};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every consumed result must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", {6'd0, bus.out_id, bus.out_data}, 32'hFFFFFFFF);
      end else begin
        e = q.pop_front();
        chk("out_data", bus.out_data, e.d);
        chk("out_id", bus.out_id, e.id);
      end
    end
  end

  task automatic send(input int k, input logic [23:0] x, input logic [23:0] y, input bit lat);
    int t;
    @(posedge clk); #1;
    bus.req_valid = 3'b000;
    bus.req_valid[k] = 1'b1;
    bus.req_data[k*24 +: 24] = x;
    q.push_back({y, 2'(k)});
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready[k] && t < 50);
    chk("single_grant", bus.req_ready, 32'(1) << k);
    @(posedge clk); #1;
    bus.req_valid[k] = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("lat_edge1_valid", bus.out_valid, 0);
      chk("lat_edge1_busy", busy, 1);
      @(negedge clk);
      chk("lat_edge2_valid", bus.out_valid, 1);
    end
  endtask

  task automatic stream(input int n);
    @(posedge clk); #1;
    bus.req_data  = {R_X[2], R_X[1], R_X[0]};
    bus.req_valid = 3'b111;
    for (int j = 0; j < n; j++) q.push_back({R_Y[seq[j]], 2'(seq[j])});
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk("rr_grant", bus.req_ready, 32'(1) << seq[j]);
    end
    @(posedge clk); #1;
    bus.req_valid = 3'b000;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] bp_rdy [5];
    bp_rdy = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000};

    rst           = 1'b1;
    cfg_mask      = 3'b111;
    bus.req_valid = 3'b111;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_id", bus.out_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_cnt", done_cnt, 0);
    bus.req_valid = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single operands, saturation and segment boundaries.
    for (int v = 0; v < NV; v++) send(int'(V_K[v]), V_X[v], V_Y[v], v == 0);
    drain();
    chk("done_after_single", done_cnt, 4'd11);

    // Fairness with all enabled, then with requester 1 masked off.
    for (int j = 0; j < 6; j++) seq[j] = j % 3;
    stream(6);
    drain();
    cfg_mask = 3'b101;
    seq[0] = 0; seq[1] = 2; seq[2] = 0; seq[3] = 2;
    stream(4);
    drain();
    cfg_mask = 3'b111;

    // Backpressure: only two operands fit, output held stable.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.req_data  = {R_X[2], R_X[1], R_X[0]};
    bus.req_valid = 3'b111;
    q.push_back({24'h080000, 2'd0});
    q.push_back({24'h090000, 2'd1});
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("bp_req_ready", bus.req_ready, bp_rdy[j]);
      if (j >= 2) begin
        chk("bp_hold_data", bus.out_data, 24'h080000);
        chk("bp_hold_id", bus.out_id, 0);
        chk("bp_busy", busy, 1);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 3'b000;
    bus.out_ready = 1'b1;
    drain();
    chk("done_after_bp", done_cnt, 4'd7);

    // Reset with both stages full; in-flight work is dropped.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.req_valid = 3'b111;
    repeat (3) @(negedge clk);
    chk("prerst_full_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 3'b110;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done_cnt", done_cnt, 0);
    chk("midrst_req_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    q.push_back({24'h090000, 2'd1});
    @(negedge clk);
    chk("postrst_grant", bus.req_ready, 3'b010);
    @(posedge clk); #1;
    bus.req_valid = 3'b000;
    drain();
    chk("done_after_rst", done_cnt, 4'd1);

    // Sixteen more results: 17 since reset wraps the 4-bit counter to 1.
    for (int j = 0; j < 16; j++) seq[j] = (2 + j) % 3;
    stream(16);
    drain();
    chk("done_wrap", done_cnt, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
